// File: rtl/spi_frame_controller.sv
// -----------------------------------------------------------------------------
// spi_frame_controller
//
// SPI mode-0 host controller for one 16-bit frame per transaction:
//   frame[15:0] = {rw, addr[6:0], wdata[7:0]}, shifted MSB first on copi.
// A one-cycle start request (taken only while idle) launches the frame.
// sclk idles low, and ncs is held low around the 16 clock pulses. cipo is
// captured on every SCLK-high phase. The last 8 captured bits are returned
// on rdata when a read frame completes.
//
// Timeline, with D = CLK_DIV and t0 = acceptance edge:
//   ncs falls at t0, SCLK rises at t0+D and has period 2D.
//   The last SCLK fall is at t0+32D.
//   ncs rises and done pulses at t0+33D.
//   busy falls at t0+34D.
//
// Parameters
//   CLK_DIV  SCLK half-period in clk cycles (1..255)
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start    transaction request (ignored while busy)
//   rw       1 = write, 0 = read (latched at acceptance)
//   addr     7-bit register address (latched at acceptance)
//   wdata    8-bit write data (latched at acceptance, shifted on reads too)
//   busy     high from acceptance until the inter-frame gap ends
//   done     one-cycle completion pulse
//   rdata    data captured from cipo on the most recent read frame
//   sclk     SPI clock, idle low
//   copi     controller-out data, 0 whenever ncs is high
//   ncs      active-low chip select
//   cipo     peripheral-out data
// -----------------------------------------------------------------------------
module spi_frame_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       copi,
    output logic       ncs,
    input  logic       cipo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_t;

    // Every timed state lasts CLK_DIV cycles; the counter runs 0..CLK_DIV-1.
    localparam logic [7:0] C_CNT_LAST = 8'(CLK_DIV - 1);

    state_t      r_state, w_state_next;
    logic [7:0]  r_cnt, w_cnt_next;
    logic [3:0]  r_bit, w_bit_next;
    logic [15:0] r_shift, w_shift_next;
    logic [7:0]  r_cap, w_cap_next;
    logic [7:0]  r_rdata, w_rdata_next;
    logic        r_rw, w_rw_next;
    logic        r_sclk, w_sclk_next;
    logic        r_copi, w_copi_next;
    logic        r_ncs, w_ncs_next;
    logic        r_done, w_done_next;
    logic        w_cnt_end;

    assign w_cnt_end = (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_bit   <= 4'd0;
            r_shift <= 16'd0;
            r_cap   <= 8'd0;
            r_rdata <= 8'd0;
            r_rw    <= 1'b0;
            r_sclk  <= 1'b0;
            r_copi  <= 1'b0;
            r_ncs   <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_cap   <= w_cap_next;
            r_rdata <= w_rdata_next;
            r_rw    <= w_rw_next;
            r_sclk  <= w_sclk_next;
            r_copi  <= w_copi_next;
            r_ncs   <= w_ncs_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = w_cnt_end ? 8'd0 : r_cnt + 8'd1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_cap_next   = r_cap;
        w_rdata_next = r_rdata;
        w_rw_next    = r_rw;
        w_sclk_next  = r_sclk;
        w_copi_next  = r_copi;
        w_ncs_next   = r_ncs;
        w_done_next  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_next = 8'd0;
                if (start) begin
                    w_shift_next = {rw, addr, wdata};
                    w_rw_next    = rw;
                    w_bit_next   = 4'd0;
                    w_ncs_next   = 1'b0;
                    w_copi_next  = rw;          // frame bit 15 is set up before the first rise
                    w_state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_cnt_end) begin
                    w_sclk_next  = 1'b1;
                    w_state_next = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_cnt_end) begin
                    // Sample cipo at the end of the high phase, then drop SCLK.
                    w_cap_next  = {r_cap[6:0], cipo};
                    w_sclk_next = 1'b0;
                    if (r_bit != 4'd15) begin
                        // Next bit goes out on the falling edge, so it is stable before the next rise.
                        w_shift_next = {r_shift[14:0], 1'b0};
                        w_copi_next  = r_shift[14];
                        w_bit_next   = r_bit + 4'd1;
                        w_state_next = S_LOW;
                    end else begin
                        w_state_next = S_HOLD;
                    end
                end
            end
            S_LOW: begin
                if (w_cnt_end) begin
                    w_sclk_next  = 1'b1;
                    w_state_next = S_HIGH;
                end
            end
            S_HOLD: begin
                if (w_cnt_end) begin
                    w_ncs_next   = 1'b1;
                    w_copi_next  = 1'b0;
                    w_done_next  = 1'b1;
                    // The capture register now holds the eight data-phase bits.
                    if (!r_rw) begin
                        w_rdata_next = r_cap;
                    end
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (w_cnt_end) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign busy  = (r_state != S_IDLE);
    assign done  = r_done;
    assign rdata = r_rdata;
    assign sclk  = r_sclk;
    assign copi  = r_copi;
    assign ncs   = r_ncs;

endmodule

// File: tb/tb_spi_frame_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_controller
//
// Two controller instances share the clock and reset:
//   instance 0 uses CLK_DIV=4 and runs directed and random frames;
//   instance 1 uses CLK_DIV=1 and runs back-to-back frames.
// A per-instance reference model predicts each accepted frame at the start edge
// from timing arithmetic, then queues the frame, the peripheral's response word,
// and the expected rdata. A separate monitor decodes the SPI bus, plays the
// peripheral on cipo, and checks every completed frame against the queue head.
// -----------------------------------------------------------------------------
module tb_spi_frame_controller;

    typedef struct {
        logic [15:0] frame;
        logic [15:0] resp;
        logic [7:0]  rdata;
        int          t0;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      start_v = '0;
    logic [1:0]      rw_v = '0;
    logic [1:0][6:0] addr_v = '0;
    logic [1:0][7:0] wdata_v = '0;
    logic [1:0][7:0] pbyte_v = '0;     // byte the peripheral returns in the data phase
    wire  [1:0]      busy_v, done_v, sclk_v, copi_v, ncs_v;
    wire  [1:0][7:0] rdata_v;

    int cyc = 0;
    int n_vec = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int inst, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s[%0d] @cyc %0d: got 0x%0h, required 0x%0h", name, inst, cyc, act, req);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int D = (gi == 0) ? 4 : 1;
        logic cipo_r;

        spi_frame_controller #(.CLK_DIV(D)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start_v[gi]),
            .rw    (rw_v[gi]),
            .addr  (addr_v[gi]),
            .wdata (wdata_v[gi]),
            .busy  (busy_v[gi]),
            .done  (done_v[gi]),
            .rdata (rdata_v[gi]),
            .sclk  (sclk_v[gi]),
            .copi  (copi_v[gi]),
            .ncs   (ncs_v[gi]),
            .cipo  (cipo_r)
        );

        // Reference model: a start is taken when the controller is free. After
        // acceptance at edge E, the next acceptance is possible at E + 34*D + 1.
        exp_t       exp_q[$];
        int         free_at = 0;
        logic [7:0] model_rdata = 8'h00;

        always @(posedge clk) begin
            exp_t e;
            if (rst) begin
                exp_q.delete();
                free_at = 0;
                model_rdata = 8'h00;
            end else if (start_v[gi] && (cyc + 1) >= free_at) begin
                e.t0    = cyc + 1;
                e.frame = {rw_v[gi], addr_v[gi], wdata_v[gi]};
                e.resp  = {8'($urandom), pbyte_v[gi]};
                if (!rw_v[gi]) model_rdata = pbyte_v[gi];
                e.rdata = model_rdata;
                exp_q.push_back(e);
                free_at = cyc + 1 + 34 * D + 1;
            end
        end

        // Bus monitor, peripheral model, and scoreboard.
        logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
        logic [15:0] rx = '0, resp = '0;
        int          nrise = 0, t_first = 0, t_lastfall = 0, last_t0 = 0;
        bit          have_last = 1'b0;

        initial cipo_r = 1'b0;

        always @(negedge clk) begin
            exp_t e;
            if (rst) begin
                prev_ncs = 1'b1; prev_sclk = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
                have_last = 1'b0; nrise = 0; cipo_r = 1'b0;
            end else begin
                if (!ncs_v[gi] && prev_ncs) begin
                    rx = '0; nrise = 0; t_first = -1; t_lastfall = -1;
                    if (exp_q.size() > 0) begin
                        resp = exp_q[0].resp;
                        chk("ncs_fall_cycle", gi, cyc, exp_q[0].t0);
                    end else begin
                        resp = '0;
                        chk("unexpected_frame", gi, 1, 0);
                    end
                end
                if (ncs_v[gi]) chk("copi_idle", gi, copi_v[gi], 0);
                if (sclk_v[gi] && !prev_sclk) begin
                    if (nrise == 0) t_first = cyc;
                    rx = {rx[14:0], copi_v[gi]};
                    if (nrise < 16) cipo_r = resp[15 - nrise];
                    nrise++;
                end
                if (!sclk_v[gi] && prev_sclk) t_lastfall = cyc;
                if (done_v[gi]) begin
                    if (prev_done) begin
                        chk("done_width", gi, 2, 1);
                    end else if (exp_q.size() == 0) begin
                        chk("spurious_done", gi, 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("inst %0d frame 0x%04h rdata 0x%02h done @cyc %0d", gi, rx, rdata_v[gi], cyc);
                        chk("frame", gi, rx, e.frame);
                        chk("sclk_rises", gi, nrise, 16);
                        chk("rdata", gi, rdata_v[gi], e.rdata);
                        chk("done_time", gi, cyc - e.t0, 33 * D);
                        chk("first_rise", gi, t_first - e.t0, D);
                        chk("last_fall", gi, t_lastfall - e.t0, 32 * D);
                        chk("ncs_at_done", gi, ncs_v[gi], 1);
                        last_t0 = e.t0;
                        have_last = 1'b1;
                    end
                end
                if (!busy_v[gi] && prev_busy && have_last) begin
                    chk("busy_fall", gi, cyc - last_t0, 34 * D);
                end
                prev_ncs  = ncs_v[gi];
                prev_sclk = sclk_v[gi];
                prev_busy = busy_v[gi];
                prev_done = done_v[gi];
            end
        end
    end

    task automatic chk_reset_outputs(input int inst);
        chk("rst_ncs", inst, ncs_v[inst], 1);
        chk("rst_sclk", inst, sclk_v[inst], 0);
        chk("rst_copi", inst, copi_v[inst], 0);
        chk("rst_busy", inst, busy_v[inst], 0);
        chk("rst_done", inst, done_v[inst], 0);
        chk("rst_rdata", inst, rdata_v[inst], 0);
    endtask

    // One start pulse to instance 0. Inputs are scrambled right after so that
    // any late latching shows up as a frame mismatch.
    task automatic send0(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                         input logic [7:0] pbyte);
        @(negedge clk);
        rw_v[0] = rw; addr_v[0] = addr; wdata_v[0] = wdata; pbyte_v[0] = pbyte;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        rw_v[0] = 1'($urandom); addr_v[0] = 7'($urandom); wdata_v[0] = 8'($urandom);
        pbyte_v[0] = 8'($urandom);
    endtask

    initial begin
        // Reset held for 3 cycles with start asserted.
        rst = 1'b1;
        start_v = 2'b11;
        repeat (3) begin
            @(negedge clk);
            chk_reset_outputs(0);
            chk_reset_outputs(1);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        start_v = 2'b00;

        // Write 0x845A: rdata must remain 0x00.
        send0(1'b1, 7'h04, 8'h5A, 8'h00);
        repeat (140) @(negedge clk);

        // Read from address 0x02, with the peripheral returning 0xC3.
        send0(1'b0, 7'h02, 8'($urandom), 8'hC3);
        repeat (140) @(negedge clk);

        // A start pulse arrives mid-frame and must be ignored.
        send0(1'b1, 7'h15, 8'hA7, 8'($urandom));
        repeat (49) @(negedge clk);
        addr_v[0] = 7'h7F; rw_v[0] = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (100) @(negedge clk);

        // Reset mid-frame: outputs respond without a clock, and no done pulse follows.
        send0(1'b1, 7'h33, 8'h66, 8'($urandom));
        repeat (59) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ncs", 0, ncs_v[0], 1);
        chk("midrst_sclk", 0, sclk_v[0], 0);
        chk("midrst_busy", 0, busy_v[0], 0);
        chk("midrst_done", 0, done_v[0], 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        send0(1'b1, 7'h00, 8'h11, 8'($urandom));
        repeat (140) @(negedge clk);

        // Random frames with random spacing.
        repeat (6) begin
            send0(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
            repeat (136 + $urandom_range(0, 6)) @(negedge clk);
        end

        // CLK_DIV=1: start held high continuously while the inputs churn.
        @(negedge clk);
        start_v[1] = 1'b1;
        repeat (200) begin
            @(negedge clk);
            rw_v[1] = 1'($urandom); addr_v[1] = 7'($urandom);
            wdata_v[1] = 8'($urandom); pbyte_v[1] = 8'($urandom);
        end
        start_v[1] = 1'b0;
        repeat (60) @(negedge clk);

        // Every accepted frame must have completed.
        chk("pending_frames", 0, g_inst[0].exp_q.size(), 0);
        chk("pending_frames", 1, g_inst[1].exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
